// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, FSM states
// and the fixed latency of a full restoring division.
package iterative_divider_pkg;

  localparam int DIV_N       = 32;
  localparam int DIV_LATENCY = DIV_N + 2;

  // Encodings follow funct3[1:0] of the M-extension divide group.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_SIGN = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, keep or restore.
module div_restore_step
  import iterative_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0] rem_sh;
  logic [N:0] diff;

  // NOTE: every output gets a value on every path through always_comb; a branch
  // that skips an assignment would infer a latch.
  always_comb begin
    rem_sh = {rem, quo[N-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[N]) begin
      rem_next = diff[N-1:0];
      quo_next = {quo[N-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[N-1:0];
      quo_next = {quo[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU. Operands are folded to
// magnitudes, divided over N cycles, then sign-corrected and registered.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  div_state_e    state, state_next;
  logic [CW-1:0] cnt;
  logic          sel_rem;
  logic          neg_q, neg_r;
  logic [N-1:0]  rem, quo, dvs_abs;
  logic [N-1:0]  rem_next, quo_next;

  logic          accept, is_signed, div_zero, overflow, special;
  logic [N-1:0]  a_abs, b_abs, special_val;

  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE);
    is_signed = op_is_signed(op);
    div_zero  = (divisor == '0);
    overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    special   = div_zero || overflow;
    // MIN_NEG negates to itself, which is exactly its magnitude read unsigned.
    a_abs     = (is_signed && dividend[N-1]) ? -dividend : dividend;
    b_abs     = (is_signed && divisor[N-1])  ? -divisor  : divisor;
    if (div_zero) special_val = op_is_rem(op) ? dividend : '1;
    else          special_val = op_is_rem(op) ? '0       : MIN_NEG;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == CNT_LAST) state_next = S_SIGN;
      S_SIGN: state_next = S_DONE;
      S_DONE: state_next = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    busy = (state == S_CALC) || (state == S_SIGN);
    done = (state == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  div_restore_step #(.N(N)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs_abs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs_abs <= '0;
      result  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      sel_rem <= op_is_rem(op);
      neg_q   <= is_signed && (dividend[N-1] ^ divisor[N-1]);
      neg_r   <= is_signed && dividend[N-1];
      rem     <= '0;
      quo     <= a_abs;
      dvs_abs <= b_abs;
      if (special) result <= special_val;
    end else if (state == S_CALC) begin
      cnt <= cnt + CW'(1);
      rem <= rem_next;
      quo <= quo_next;
    end else if (state == S_SIGN) begin
      // Remainder sign follows the dividend; quotient truncates toward zero.
      if (sel_rem) result <= neg_r ? -rem : rem;
      else         result <= neg_q ? -quo : quo;
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed vector table, hand-written
// multi-cycle corner sequences, and random ops against an arithmetic model.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend, divisor, result;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iterative_divider #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b01:   return 32'(ua / ub);
      2'b10:   return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LATENCY;
  endfunction

  // Called at a negedge; returns at the negedge of cycle T+1 with operands scrambled.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    op       = 2'($urandom);
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [N-1:0] exp_res);
    int lat = 1;
    int busy_cycles = 0;
    while (!done && lat < 4 * DIV_LATENCY) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(busy_cycles), 64'(exp_lat - 1));
    check({name, " result"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        32'd14,        DIV_LATENCY});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,        32'd2,         DIV_LATENCY});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, DIV_LATENCY});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, DIV_LATENCY});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LATENCY});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LATENCY});
    vecs.push_back('{OP_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF, 1});
    vecs.push_back('{OP_REMU, 32'h8000_0000,  32'd0,        32'h8000_0000, 1});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         DIV_LATENCY});
    vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, DIV_LATENCY});
    vecs.push_back('{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        DIV_LATENCY});
    vecs.push_back('{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, DIV_LATENCY});
    vecs.push_back('{OP_DIVU, 32'd0,          32'd5,        32'd0,         DIV_LATENCY});
    vecs.push_back('{OP_REMU, 32'd5,          32'd0,        32'd5,         1});

    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset result", 64'(result), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].res);
    end

    // Start requests while busy must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (3) begin
      start    = 1'b1;
      op       = OP_DIV;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done("busy-ignore", DIV_LATENCY - 3, 32'd14);

    // Reset in the middle of CALC clears everything and suppresses done.
    issue(OP_DIVU, 32'd12345, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset done", 64'(done), 64'(0));
    check("midreset result", 64'(result), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (DIV_LATENCY + 4) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("midreset no done/busy", 64'(seen), 64'(0));
    end

    // Back-to-back: a new op accepted in the DONE cycle.
    issue(OP_DIVU, 32'd9, 32'd3);
    wait_done("b2b first", DIV_LATENCY, 32'd3);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    check("b2b done drops", 64'(done), 64'(0));
    check("b2b busy rises", 64'(busy), 64'(1));
    check("b2b held result", 64'(result), 64'(3));
    wait_done("b2b second", DIV_LATENCY, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      if (i % 7 == 0) @(negedge clk);
      issue(o, a, b);
      wait_done($sformatf("rand%0d op%0d 0x%0h/0x%0h", i, o, a, b),
                ref_latency(o, a, b), ref_result(o, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
